// File: rtl/scancode_ascii_decoder_if.sv
// Byte-in / character-out bus of the scancode decoder: receiver strobe side and
// the valid/ready character pop side. slave = decoder, master = its environment.
interface scancode_ascii_decoder_if;
    logic [7:0] code_i;
    logic       code_valid_i;
    logic [7:0] ascii_o;
    logic [7:0] key_o;
    logic       ascii_valid_o;
    logic       ascii_ready_i;

    modport slave (
        input  code_i, code_valid_i, ascii_ready_i,
        output ascii_o, key_o, ascii_valid_o
    );

    modport master (
        output code_i, code_valid_i, ascii_ready_i,
        input  ascii_o, key_o, ascii_valid_o
    );
endinterface

// File: rtl/scancode_ascii_decoder.sv
// PS/2 set-2 scancode to ASCII decoder with prefix FSM, Shift tracking and a character FIFO.
// Optional Caps Lock support is enabled by defining KBD_CAPSLOCK_EN.
module scancode_ascii_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    scancode_ascii_decoder_if.slave       bus,
    output logic                          key_held_o,
    output logic                          shift_o,
    output logic                          caps_o,
    output logic [CNT_W-1:0]              press_cnt_o,
    output logic                          overflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       held_q, held_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
`ifdef KBD_CAPSLOCK_EN
    logic             caps_q, caps_d;
`endif

    logic             caps_now;
    logic             upper;
    logic [7:0]       code_letter;
    logic [7:0]       code_other;
    logic             code_hit;
    logic [7:0]       code_char;
    logic [PTR_W-1:0] occupancy;
    logic             full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             wr_en;

    function automatic logic [7:0] letter_of(input logic [7:0] code);
        case (code)
            8'h1C: letter_of = "a";   8'h32: letter_of = "b";   8'h21: letter_of = "c";
            8'h23: letter_of = "d";   8'h24: letter_of = "e";   8'h2B: letter_of = "f";
            8'h34: letter_of = "g";   8'h33: letter_of = "h";   8'h43: letter_of = "i";
            8'h3B: letter_of = "j";   8'h42: letter_of = "k";   8'h4B: letter_of = "l";
            8'h3A: letter_of = "m";   8'h31: letter_of = "n";   8'h44: letter_of = "o";
            8'h4D: letter_of = "p";   8'h15: letter_of = "q";   8'h2D: letter_of = "r";
            8'h1B: letter_of = "s";   8'h2C: letter_of = "t";   8'h3C: letter_of = "u";
            8'h2A: letter_of = "v";   8'h1D: letter_of = "w";   8'h22: letter_of = "x";
            8'h35: letter_of = "y";   8'h1A: letter_of = "z";
            default: letter_of = 8'h00;
        endcase
    endfunction

    // Digits follow Shift only; space ignores it.
    function automatic logic [7:0] other_of(input logic [7:0] code, input logic shift);
        case (code)
            8'h16: other_of = shift ? "!" : "1";
            8'h1E: other_of = shift ? "@" : "2";
            8'h26: other_of = shift ? "#" : "3";
            8'h25: other_of = shift ? "$" : "4";
            8'h2E: other_of = shift ? "%" : "5";
            8'h36: other_of = shift ? "^" : "6";
            8'h3D: other_of = shift ? "&" : "7";
            8'h3E: other_of = shift ? "*" : "8";
            8'h46: other_of = shift ? "(" : "9";
            8'h45: other_of = shift ? ")" : "0";
            8'h29: other_of = " ";
            default: other_of = 8'h00;
        endcase
    endfunction

`ifdef KBD_CAPSLOCK_EN
    assign caps_now = caps_q;
`else
    assign caps_now = 1'b0;
`endif

    assign upper       = (lshift_q | rshift_q) ^ caps_now;
    assign code_letter = letter_of(bus.code_i);
    assign code_other  = other_of(bus.code_i, lshift_q | rshift_q);
    assign code_hit    = (code_letter != 8'h00) || (code_other != 8'h00);
    assign code_char   = (code_letter != 8'h00) ? (upper ? code_letter - 8'h20 : code_letter)
                                                : code_other;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = occupancy[PTR_W-1];
    assign not_empty = (occupancy != '0);

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
`ifdef KBD_CAPSLOCK_EN
        caps_d   = caps_q;
`endif
        if (bus.code_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.code_i == 8'hF0) state_d = ST_BRK;
                    else if (bus.code_i == 8'hE0) state_d = ST_EXT;
                    else if (bus.code_i == 8'h12) lshift_d = 1'b1;
                    else if (bus.code_i == 8'h59) rshift_d = 1'b1;
`ifdef KBD_CAPSLOCK_EN
                    else if (bus.code_i == 8'h58) begin
                        // Caps Lock uses the held-code slot so auto-repeat cannot re-toggle it.
                        if (held_q != 8'h58) begin
                            caps_d = ~caps_q;
                            held_d = 8'h58;
                        end
                    end
`endif
                    else if (code_hit && (bus.code_i != held_q)) begin
                        held_d = bus.code_i;
                        cnt_d  = cnt_q + CNT_W'(1);
                        push   = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (bus.code_i == 8'h12) lshift_d = 1'b0;
                    else if (bus.code_i == 8'h59) rshift_d = 1'b0;
                    else if (bus.code_i == held_q) held_d = 8'h00;
                end
                ST_EXT:     state_d = (bus.code_i == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end

        pop   = not_empty && bus.ascii_ready_i;
        wr_en = push && (!full || pop);
        if (push && full && !pop) ovf_d = 1'b1;
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            held_q   <= 8'h00;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef KBD_CAPSLOCK_EN
            caps_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef KBD_CAPSLOCK_EN
            caps_q   <= caps_d;
`endif
        end
    end

    // Storage needs no reset: emptiness is decided by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) fifo_mem[wr_ptr_q[PTR_W-2:0]] <= {code_char, bus.code_i};
    end

    assign bus.ascii_valid_o = not_empty;
    assign bus.ascii_o       = not_empty ? fifo_mem[rd_ptr_q[PTR_W-2:0]][15:8] : 8'h00;
    assign bus.key_o         = not_empty ? fifo_mem[rd_ptr_q[PTR_W-2:0]][7:0]  : 8'h00;
    assign key_held_o        = (held_q != 8'h00) && (held_q != 8'h58);
    assign shift_o           = lshift_q | rshift_q;
    assign caps_o            = caps_now;
    assign press_cnt_o       = cnt_q;
    assign overflow_o        = ovf_q;
endmodule

// File: tb/tb_scancode_ascii_decoder.sv
// Directed + randomized bench for scancode_ascii_decoder against a table-driven reference model.
module tb_scancode_ascii_decoder;
    localparam int DEPTH = 8;
`ifdef KBD_CAPSLOCK_EN
    localparam bit CAPS_EN = 1'b1;
`else
    localparam bit CAPS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_held_o, shift_o, caps_o, overflow_o;
    logic [7:0] press_cnt_o;
    int         errors = 0;
    int         checks = 0;

    scancode_ascii_decoder_if bus();

    scancode_ascii_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .key_held_o (key_held_o),
        .shift_o    (shift_o),
        .caps_o     (caps_o),
        .press_cnt_o(press_cnt_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference tables built from the key map.
    logic [7:0] char_tab [logic [7:0]];
    logic [7:0] dsh_tab  [logic [7:0]];

    // Reference state.
    logic [15:0] m_q[$];
    bit          m_f0, m_e0, m_ls, m_rs, m_caps, m_ovf;
    logic [7:0]  m_held;
    logic [7:0]  m_cnt;

    task automatic build_tables();
        logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                     8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                     8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
        logic [7:0] digits [10]  = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
        logic [7:0] dchar  [10]  = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30};
        logic [7:0] dshift [10]  = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29};
        for (int i = 0; i < 26; i++) char_tab[letters[i]] = 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) begin
            char_tab[digits[i]] = dchar[i];
            dsh_tab[digits[i]]  = dshift[i];
        end
        char_tab[8'h29] = 8'h20;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_f0 = 0; m_e0 = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_ovf = 0;
        m_held = 8'h00; m_cnt = 8'h00;
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] b);
        logic [7:0] c;
        bit sh;
        c  = char_tab[b];
        sh = m_ls | m_rs;
        if (c >= 8'h61 && c <= 8'h7A) return (sh ^ m_caps) ? c - 8'h20 : c;
        if (sh && dsh_tab.exists(b)) return dsh_tab[b];
        return c;
    endfunction

    // Applies one clock edge of input activity to the reference model.
    task automatic model_edge(input bit vld, input logic [7:0] b, input bit rdy);
        bit          do_push = 0;
        bit          do_pop;
        logic [15:0] ent = '0;
        do_pop = (m_q.size() != 0) && rdy;
        if (vld) begin
            if (m_f0) begin
                if (!m_e0) begin
                    if (b == 8'h12) m_ls = 0;
                    else if (b == 8'h59) m_rs = 0;
                    else if (b == m_held) m_held = 8'h00;
                end
                m_f0 = 0; m_e0 = 0;
            end else if (m_e0) begin
                if (b == 8'hF0) m_f0 = 1; else m_e0 = 0;
            end else if (b == 8'hF0) m_f0 = 1;
            else if (b == 8'hE0) m_e0 = 1;
            else if (b == 8'h12) m_ls = 1;
            else if (b == 8'h59) m_rs = 1;
            else if (CAPS_EN && b == 8'h58) begin
                if (m_held != 8'h58) begin m_caps = !m_caps; m_held = 8'h58; end
            end else if (char_tab.exists(b) && b != m_held) begin
                ent = {model_char(b), b};
                m_held = b;
                m_cnt++;
                do_push = 1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ent);
            else m_ovf = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] ea, ek;
        ea = (m_q.size() != 0) ? m_q[0][15:8] : 8'h00;
        ek = (m_q.size() != 0) ? m_q[0][7:0]  : 8'h00;
        chk({tag, ".ascii"}, 32'(bus.ascii_o), 32'(ea));
        chk({tag, ".key"},   32'(bus.key_o),   32'(ek));
        chk({tag, ".valid"}, 32'(bus.ascii_valid_o), 32'(m_q.size() != 0));
        chk({tag, ".held"},  32'(key_held_o), 32'(m_held != 8'h00 && m_held != 8'h58));
        chk({tag, ".shift"}, 32'(shift_o), 32'(m_ls | m_rs));
        chk({tag, ".caps"},  32'(caps_o), 32'(m_caps));
        chk({tag, ".cnt"},   32'(press_cnt_o), 32'(m_cnt));
        chk({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
    endtask

    // Inputs are changed at the falling edge; outputs are sampled at the next falling edge.
    task automatic step(input bit vld, input logic [7:0] b, input bit rdy, input string tag);
        bus.code_valid_i  = vld;
        bus.code_i        = b;
        bus.ascii_ready_i = rdy;
        model_edge(vld, b, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        step(1'b1, b, rdy, $sformatf("byte%02h", b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.code_valid_i  = 1'b1;
        bus.code_i        = 8'h1C;
        bus.ascii_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.code_valid_i = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        int pops;
        logic [7:0] pool [] = '{8'h1C,8'h32,8'h21,8'h16,8'h1E,8'h45,8'h29,8'h1A,8'h44,8'h3E,
                                8'hF0,8'hF0,8'hF0,8'hE0,8'h12,8'h59,8'h58,8'h0E,8'h75,8'h00};
        bus.code_valid_i  = 1'b0;
        bus.code_i        = 8'h00;
        bus.ascii_ready_i = 1'b0;
        build_tables();
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst.valid0", 32'(bus.ascii_valid_o), 32'd0);
        chk("rst.cnt0",   32'(press_cnt_o), 32'd0);

        // Single press and release with no consumer.
        send(8'h1C, 0);
        chk("t1.held_rise", 32'(key_held_o), 32'd1);
        send(8'hF0, 0);
        send(8'h1C, 0);
        chk("t1.held_fall", 32'(key_held_o), 32'd0);
        chk("t1.ascii",     32'(bus.ascii_o), 32'h61);
        chk("t1.key",       32'(bus.key_o), 32'h1C);
        chk("t1.cnt",       32'(press_cnt_o), 32'd1);

        // Shifted letter and digit, then unshifted letter, consumer always ready.
        do_reset();
        send(8'h12, 1);
        chk("t2.shift_on", 32'(shift_o), 32'd1);
        send(8'h1C, 1);
        chk("t2.A", 32'(bus.ascii_o), 32'h41);
        send(8'h16, 1);
        chk("t2.bang", 32'(bus.ascii_o), 32'h21);
        send(8'hF0, 1); send(8'h16, 1); send(8'hF0, 1); send(8'h1C, 1);
        send(8'hF0, 1); send(8'h12, 1);
        chk("t2.shift_off", 32'(shift_o), 32'd0);
        send(8'h32, 1);
        chk("t2.b", 32'(bus.ascii_o), 32'h62);

        // Typematic repeats.
        do_reset();
        send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
        chk("t3.cnt", 32'(press_cnt_o), 32'd1);
        step(1'b0, 8'h00, 1'b1, "t3.pop");
        chk("t3.one_entry", 32'(bus.ascii_valid_o), 32'd0);

        // Extended sequences and an unmapped code.
        do_reset();
        send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        send(8'h0E, 0);
        chk("t4.nopush", 32'(bus.ascii_valid_o), 32'd0);
        chk("t4.cnt",    32'(press_cnt_o), 32'd0);
        send(8'h23, 0);
        chk("t4.d", 32'(bus.ascii_o), 32'h64);

        // Fill past capacity, then push with pop while full.
        do_reset();
        begin
            logic [7:0] dg [9] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
            for (int i = 0; i < 9; i++) begin
                send(dg[i], 0); send(8'hF0, 0); send(dg[i], 0);
            end
        end
        chk("t5.ovf", 32'(overflow_o), 32'd1);
        chk("t5.cnt", 32'(press_cnt_o), 32'd9);
        chk("t5.head", 32'(bus.ascii_o), 32'h31);
        send(8'h45, 1);
        chk("t5.head_after", 32'(bus.ascii_o), 32'h32);
        pops = 0;
        for (int i = 0; i < 20 && bus.ascii_valid_o; i++) begin
            step(1'b0, 8'h00, 1'b1, "t5.drain");
            pops++;
        end
        chk("t5.occupancy", 32'(pops), 32'd8);
        send(8'hF0, 0); send(8'h45, 0); send(8'h1C, 0);
        do_reset();
        chk("t5.rst_ovf",  32'(overflow_o), 32'd0);
        chk("t5.rst_held", 32'(key_held_o), 32'd0);

        if (CAPS_EN) begin
            send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0);
            chk("t6.caps", 32'(caps_o), 32'd1);
            send(8'h1C, 0);
            chk("t6.A", 32'(bus.ascii_o), 32'h41);
            send(8'hF0, 0); send(8'h1C, 0); send(8'h12, 0); send(8'h1C, 0);
            step(1'b0, 8'h00, 1'b1, "t6.pop");
            chk("t6.a", 32'(bus.ascii_o), 32'h61);
            do_reset();
        end

        // Randomized traffic, including back-to-back strobes and mid-run resets.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step(($urandom_range(0, 3) != 0), pool[$urandom_range(0, pool.size() - 1)],
                 ($urandom_range(0, 2) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scancode_ascii_decoder.md
Name: scancode_ascii_decoder

Overview:
- Sequential successor to the combinational scancode-to-ASCII lookup.
- Consumes PS/2 set-2 scancode bytes from the keyboard receiver and tracks make/break/extended prefixes and Shift state.
- Emits one ASCII character per new key press into a parametrised FIFO, read by the display/terminal logic through a valid/ready pop interface.

Parameters:
FIFO_DEPTH, 8, number of character entries buffered; power of 2, minimum 2
CNT_W, 8, width of the key-press counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
code_i  input  8  scancode byte from PS/2 receiver
code_valid_i  input  1  one-cycle strobe: code_i valid this cycle
ascii_o  output  8  ASCII at FIFO head; 0x00 when empty
key_o  output  8  make scancode paired with ascii_o; 0x00 when empty
ascii_valid_o  output  1  FIFO not empty
ascii_ready_i  input  1  consumer pops head when ascii_valid_o & ascii_ready_i
key_held_o  output  1  a mapped non-modifier key is currently held
shift_o  output  1  left or right Shift held
caps_o  output  1  Caps Lock state (see Optional Feature)
press_cnt_o  output  CNT_W  count of accepted key presses, wraps modulo 2^CNT_W
overflow_o  output  1  sticky: a character was dropped because the FIFO was full

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst=1 at a clock edge:
  - All outputs go to 0, FIFO is emptied, FSM goes to IDLE, held code cleared.
  - code_valid_i and pops in that cycle are ignored.
- Prefix FSM advances only on code_valid_i. States and transitions:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, then stay IDLE.
  - BRK: next byte is a break code -> IDLE.
  - EXT: F0 -> EXT_BRK; other byte is an extended make, ignored -> IDLE.
  - EXT_BRK: any byte ignored -> IDLE.
- Make code handling:
  - 0x12 or 0x59: set the corresponding shift flag; never pushed.
  - Mapped code, equal to the held code (typematic repeat): suppressed, no push, no count.
  - Mapped code, otherwise: held code := code_i; key_held_o=1; press_cnt_o+1; push {ascii, code} to the FIFO.
  - Unmapped code: ignored, no push, no count, held code unchanged.
- Break code handling:
  - 0x12/0x59: clear the corresponding shift flag.
  - Equal to the held code: clear held code; key_held_o=0.
  - Otherwise: no effect.
- Mapping (set-2):
  - Digits 16,1E,26,25,2E,36,3D,3E,46,45 -> '1'..'9','0'.
  - Letters 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - 0x29 -> space (0x20).
  - Shift is sampled at the push cycle:
    - letters -> uppercase (value - 0x20);
    - digits 1..0 -> ! @ # $ % ^ & * ( ).
    - Space is unaffected by Shift.
- Latency:
  - Make strobe at edge N -> entry written at edge N; ascii_valid_o=1 and ascii_o valid after edge N (visible in cycle N+1).
  - shift_o, key_held_o and press_cnt_o update at the same edge.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - ascii_o/key_o are combinational from the head entry, forced to 0x00 when empty.
  - Pop on an empty FIFO: no effect.
  - Push and pop in the same cycle: both happen, occupancy unchanged; allowed when full.
  - Push while full with no pop: entry dropped; overflow_o set and held until rst. press_cnt_o still increments.
- Simultaneous events: a strobe every cycle is legal; each byte is processed in arrival order with no stall.

Optional Feature:
- Macro: KBD_CAPSLOCK_EN.
- Defined:
  - Make of 0x58 toggles caps_o. Typematic repeats are suppressed via the held-code rule; 0x58 is not pushed and not counted.
  - Letter case = shift XOR caps. Digits depend on Shift only.
- Undefined:
  - 0x58 is an unmapped code (ignored).
  - caps_o tied to 0; letter case depends on Shift only.

Test Plan:
- Reset, then bytes 1C, F0, 1C with ascii_ready_i=0 -> one entry ascii_o=0x61, key_o=0x1C; press_cnt_o=1; key_held_o rises after 1C and falls after break.
- Bytes 12, 1C, 16, F0, 16, F0, 1C, F0, 12, then 32, with ascii_ready_i=1 -> pops 0x41, 0x21, then 0x62; shift_o high between the 12 make and break.
- Bytes 1C, 1C, 1C, F0, 1C -> exactly one push; press_cnt_o=1.
- Bytes E0, 75, E0, F0, 75, then 0E (unmapped) -> no push; press_cnt_o unchanged; FSM back in IDLE (next 23 pushes 0x64).
- FIFO_DEPTH=8, ascii_ready_i=0, 9 distinct presses (with breaks) -> 8 entries, overflow_o=1, press_cnt_o=9. Next, push with simultaneous pop when full -> occupancy stays 8. Then rst -> all outputs 0.
- KBD_CAPSLOCK_EN defined: 58, F0, 58, then 1C -> caps_o=1, push 0x41. Then 12, 1C (new press after a break) -> push 0x61.
